// File: rtl/prng_draw_arbiter.sv
// Seeds a shared xorshift generator, discards warm-up outputs, then hands each
// fresh generator output to at most one requester under round-robin arbitration.
//
// state | meaning
// IDLE  | unseeded; requests ignored, waiting for a seed offer
// SEED  | gen_set high for one cycle while the generator loads
// WARM  | discarding WARMUP generator outputs
// RUN   | granting one generator output per cycle
module prng_draw_arbiter #(
  parameter int          N_REQ        = 4,
  parameter int          WARMUP       = 16,
  parameter logic [63:0] SEED_DEFAULT = 64'h9E3779B97F4A7C15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic [63:0]      seed_a,
  input  logic [63:0]      seed_b,
  output logic             gen_set,
  output logic [63:0]      gen_seed1,
  output logic [63:0]      gen_seed2,
  input  logic [63:0]      gen_result,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [63:0]      rnd_data,
  output logic             rng_ok
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(WARMUP + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEED, S_WARM, S_RUN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [PW-1:0]    ptr, ptr_nxt;
  logic [PW-1:0]    idx, sel;
  logic             hit;
  logic             accept;
  logic             set_nxt, ok_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [63:0]      rnd_nxt, seed1_nxt, seed2_nxt;

  assign seed_ready = (state == S_IDLE) || (state == S_RUN);
  assign accept     = seed_valid & seed_ready;

  // First requester at or after ptr, searching circularly.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (!hit && req[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    gnt_nxt   = '0;
    rnd_nxt   = rnd_data;
    seed1_nxt = gen_seed1;
    seed2_nxt = gen_seed2;
    set_nxt   = 1'b0;
    ok_nxt    = rng_ok;

    if (accept) begin
      // An all-zero seed would lock xorshift at zero.
      seed1_nxt = ((seed_a == '0) && (seed_b == '0)) ? SEED_DEFAULT : seed_a;
      seed2_nxt = seed_b;
      set_nxt   = 1'b1;
      ok_nxt    = 1'b0;
      state_nxt = S_SEED;
    end else begin
      unique case (state)
        S_IDLE: ;
        S_SEED: begin
          cnt_nxt   = '0;
          state_nxt = S_WARM;
        end
        S_WARM: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == CW'(WARMUP - 1)) begin
            state_nxt = S_RUN;
            ok_nxt    = 1'b1;
          end
        end
        S_RUN: begin
          if (hit) begin
            gnt_nxt[sel] = 1'b1;
            rnd_nxt      = gen_result;
            ptr_nxt      = (sel == PW'(N_REQ - 1)) ? '0 : sel + 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ptr       <= '0;
      gnt       <= '0;
      rnd_data  <= '0;
      gen_set   <= 1'b0;
      gen_seed1 <= '0;
      gen_seed2 <= '0;
      rng_ok    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      rnd_data  <= rnd_nxt;
      gen_set   <= set_nxt;
      gen_seed1 <= seed1_nxt;
      gen_seed2 <= seed2_nxt;
      rng_ok    <= ok_nxt;
    end
  end

endmodule

// File: tb/tb_prng_draw_arbiter.sv
// Directed bench for prng_draw_arbiter with a small xorshift64 generator model
// attached to the gen_* ports.
module tb_prng_draw_arbiter;

  localparam int          N  = 4;
  localparam int          W  = 4;
  localparam logic [63:0] SD = 64'h9E3779B97F4A7C15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          seed_valid = 1'b0;
  logic          seed_ready;
  logic [63:0]   seed_a = '0, seed_b = '0;
  logic          gen_set;
  logic [63:0]   gen_seed1, gen_seed2, gen_result;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt;
  logic [63:0]   rnd_data;
  logic          rng_ok;
  logic [63:0]   g_state = 64'd1;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [198:0] RST_VEC = {4'b0, 64'b0, 1'b0, 64'b0, 64'b0, 1'b0, 1'b1};

  prng_draw_arbiter #(.N_REQ(N), .WARMUP(W), .SEED_DEFAULT(SD)) dut (
    .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed_ready(seed_ready),
    .seed_a(seed_a), .seed_b(seed_b), .gen_set(gen_set), .gen_seed1(gen_seed1),
    .gen_seed2(gen_seed2), .gen_result(gen_result), .req(req), .gnt(gnt),
    .rnd_data(rnd_data), .rng_ok(rng_ok)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] xs(input logic [63:0] v);
    logic [63:0] x;
    x = v;
    x = x ^ (x << 13);
    x = x ^ (x >> 7);
    x = x ^ (x << 17);
    return x;
  endfunction

  always @(posedge clk) begin
    if (gen_set) g_state <= ((gen_seed1 ^ gen_seed2) == '0) ? 64'd1 : (gen_seed1 ^ gen_seed2);
    else         g_state <= xs(g_state);
  end
  assign gen_result = g_state;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    vectors++;
    if ({gnt, rnd_data, gen_set, gen_seed1, gen_seed2, rng_ok, seed_ready} !== RST_VEC) begin
      miscompares++;
      $display("FAIL reset_values: got %h want %h",
               {gnt, rnd_data, gen_set, gen_seed1, gen_seed2, rng_ok, seed_ready}, RST_VEC);
    end
    tick;
    rst_n = 1'b1;
    req = 4'b1111;
    tick;
    vectors++;
    if (gnt !== 4'b0000) begin
      miscompares++;
      $display("FAIL idle_no_gnt: got %b want 0000", gnt);
    end
    req = '0;
  endtask

  // Accepts a seed offer and follows the block into RUN (fifth edge after accept).
  task automatic test_seeding(input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] e1, input logic [63:0] e2);
    seed_a = a;
    seed_b = b;
    seed_valid = 1'b1;
    vectors++;
    if (seed_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL seed_ready_offer: got %b want 1", seed_ready);
    end
    tick;
    seed_valid = 1'b0;
    vectors++;
    if ({gen_set, gen_seed1, gen_seed2, rng_ok, gnt, seed_ready} !== {1'b1, e1, e2, 1'b0, 4'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL seed_load: got set=%b s1=%h s2=%h ok=%b gnt=%b rdy=%b want set=1 s1=%h s2=%h ok=0 gnt=0000 rdy=0",
               gen_set, gen_seed1, gen_seed2, rng_ok, gnt, seed_ready, e1, e2);
    end
    for (int k = 1; k <= 5; k++) begin
      tick;
      vectors++;
      if ({gen_set, gnt, rng_ok, seed_ready} !== {1'b0, 4'b0, (k == 5), (k == 5)}) begin
        miscompares++;
        $display("FAIL warm_edge[%0d]: got set=%b gnt=%b ok=%b rdy=%b want set=0 gnt=0000 ok=%0d rdy=%0d",
                 k, gen_set, gnt, rng_ok, seed_ready, (k == 5), (k == 5));
      end
      if (k == 1) begin
        vectors++;
        if ({gen_seed1, gen_seed2} !== {e1, e2}) begin
          miscompares++;
          $display("FAIL seed_hold: got %h %h want %h %h", gen_seed1, gen_seed2, e1, e2);
        end
      end
    end
  endtask

  task automatic run_grants(input string tag, input logic [N-1:0] r,
                            input logic [N-1:0] exp_g [6], input int n);
    logic [63:0] exp_v, prev;
    prev = '0;
    req = r;
    for (int i = 0; i < n; i++) begin
      exp_v = gen_result;
      tick;
      vectors++;
      if (gnt !== exp_g[i] || rnd_data !== exp_v) begin
        miscompares++;
        $display("FAIL %s[%0d]: got gnt=%b rnd=%h want gnt=%b rnd=%h", tag, i, gnt, rnd_data, exp_g[i], exp_v);
      end
      if (i > 0) begin
        vectors++;
        if (rnd_data !== xs(prev)) begin
          miscompares++;
          $display("FAIL %s_seq[%0d]: got %h want %h", tag, i, rnd_data, xs(prev));
        end
      end
      prev = rnd_data;
    end
    req = '0;
    tick;
    vectors++;
    if (gnt !== 4'b0000 || rnd_data !== prev) begin
      miscompares++;
      $display("FAIL %s_idle: got gnt=%b rnd=%h want gnt=0000 rnd=%h", tag, gnt, rnd_data, prev);
    end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] e [6];
    e = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    run_grants("rr", 4'b1011, e, 6);
  endtask

  task automatic test_single;
    logic [N-1:0] e [6];
    e = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    run_grants("single", 4'b0001, e, 5);
  endtask

  task automatic test_reseed;
    logic [63:0] exp_v;
    req = 4'b1111;
    test_seeding(64'd5, 64'd6, 64'd5, 64'd6);
    exp_v = gen_result;
    tick;
    vectors++;
    if (gnt !== 4'b0010 || rnd_data !== exp_v) begin
      miscompares++;
      $display("FAIL reseed_resume: got gnt=%b rnd=%h want gnt=0010 rnd=%h", gnt, rnd_data, exp_v);
    end
  endtask

  task automatic test_zero_seed;
    logic [63:0] exp_v;
    req = 4'b0101;
    test_seeding(64'd0, 64'd0, SD, 64'd0);
    exp_v = gen_result;
    tick;
    vectors++;
    if (gnt !== 4'b0100 || rnd_data !== exp_v) begin
      miscompares++;
      $display("FAIL zero_seed_grant: got gnt=%b rnd=%h want gnt=0100 rnd=%h", gnt, rnd_data, exp_v);
    end
    req = '0;
  endtask

  task automatic test_async_reset;
    // Reset while gen_set is high.
    seed_a = 64'd7;
    seed_b = 64'd8;
    seed_valid = 1'b1;
    tick;
    seed_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({gnt, rnd_data, gen_set, gen_seed1, gen_seed2, rng_ok, seed_ready} !== RST_VEC) begin
      miscompares++;
      $display("FAIL async_seed: got %h want %h",
               {gnt, rnd_data, gen_set, gen_seed1, gen_seed2, rng_ok, seed_ready}, RST_VEC);
    end
    #1 rst_n = 1'b1;
    // Reset during WARM.
    seed_valid = 1'b1;
    tick;
    seed_valid = 1'b0;
    tick;
    tick;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({gnt, rnd_data, gen_set, gen_seed1, gen_seed2, rng_ok, seed_ready} !== RST_VEC) begin
      miscompares++;
      $display("FAIL async_warm: got %h want %h",
               {gnt, rnd_data, gen_set, gen_seed1, gen_seed2, rng_ok, seed_ready}, RST_VEC);
    end
    #1 rst_n = 1'b1;
    test_seeding(64'd1, 64'd2, 64'd1, 64'd2);
    req = 4'b1111;
    tick;
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL ptr_after_reset: got %b want 0001", gnt);
    end
    // Reset during a grant cycle.
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({gnt, rnd_data, gen_set, gen_seed1, gen_seed2, rng_ok, seed_ready} !== RST_VEC) begin
      miscompares++;
      $display("FAIL async_grant: got %h want %h",
               {gnt, rnd_data, gen_set, gen_seed1, gen_seed2, rng_ok, seed_ready}, RST_VEC);
    end
    req = '0;
    #1 rst_n = 1'b1;
    test_seeding(64'd1, 64'd2, 64'd1, 64'd2);
  endtask

  initial begin
    test_reset;
    test_seeding(64'd1, 64'd2, 64'd1, 64'd2);
    test_round_robin;
    test_single;
    test_reseed;
    test_zero_seed;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
